cic_d_tdm: RTL and testbench

//  Multichannel, time-multiplexed CIC decimator with runtime-programmable ratio and output gain shift.
//  One shared integrator/comb datapath serves NUM_CH interleaved channels; per-channel state lives in register arrays.

---
 rtl/cic_d_tdm_pkg.sv | 28 ++
 rtl/cic_d_tdm_if.sv | 12 +
 rtl/cic_d_tdm_comb_engine.sv | 96 +++++++++
 rtl/cic_d_tdm.sv | 120 ++++++++++++
 tb/tb_cic_d_tdm.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cic_d_tdm_pkg.sv
// Shared types and elaboration helpers for the TDM CIC decimator.
package cic_d_tdm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMB,
        OUT
    } comb_st_t;

    function automatic int clog2_l(input longint v);
        int r;
        r = 0;
        for (int i = 0; i < 62; i++)
            if ((64'sd1 <<< i) < v) r = i + 1;
        return r;
    endfunction

    // Full unpruned register width: bit growth of (R*M)^N plus input width
    function automatic int cic_bmax(input int r_max, input int m,
                                    input int n, input int dw);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++)
            p = p * longint'(r_max * m);
        return clog2_l(p) + dw;
    endfunction

endpackage

// File: rtl/cic_d_tdm_if.sv
// Sample stream bundle: data, channel tag and one-cycle strobe.
interface cic_d_tdm_if #(
    parameter int DW   = 18,
    parameter int CH_W = 2
);
    logic signed [DW-1:0] samp_data;
    logic [CH_W-1:0]      samp_ch;
    logic                 samp_str;

    modport master (output samp_data, samp_ch, samp_str);
    modport slave  (input  samp_data, samp_ch, samp_str);
endinterface

// File: rtl/cic_d_tdm_comb_engine.sv
// Shared comb engine: one stage per clock over per-channel delay
// memory, then gain shift, truncation and registered output.
module cic_comb_engine
    import cic_d_tdm_pkg::*;
#(
    parameter int B_MAX  = 22,
    parameter int OUT_DW = 18,
    parameter int CIC_N  = 5,
    parameter int CIC_M  = 1,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sync_clr,
    input  logic [7:0]              cfg_shift,
    input  logic                    cap_vld,
    input  logic signed [B_MAX-1:0] cap_data,
    input  logic [CH_W-1:0]         cap_ch,
    cic_d_tdm_if.master             out_samp,
    output logic                    ovf_err
);
    localparam int SW = (CIC_N > 1) ? clog2_l(longint'(CIC_N)) : 1;
    localparam logic [SW-1:0] LAST_STG = SW'(CIC_N - 1);

    comb_st_t st;
    logic signed [B_MAX-1:0] x, y, y_sh;
    logic signed [B_MAX-1:0] dly [NUM_CH][CIC_N][CIC_M];
    logic signed [OUT_DW-1:0] out_d;
    logic [CH_W-1:0] ch;
    logic [SW-1:0]   stg;

    assign y     = x - dly[ch][stg][CIC_M-1];
    assign y_sh  = x <<< cfg_shift;
    assign out_d = OUT_DW'(y_sh >>> (B_MAX - OUT_DW));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st      <= IDLE;
            x       <= '0;
            ch      <= '0;
            stg     <= '0;
            ovf_err <= 1'b0;
            out_samp.samp_data <= '0;
            out_samp.samp_ch   <= '0;
            out_samp.samp_str  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                for (int s = 0; s < CIC_N; s++)
                    for (int j = 0; j < CIC_M; j++)
                        dly[c][s][j] <= '0;
        end else if (sync_clr) begin
            st      <= IDLE;
            x       <= '0;
            ch      <= '0;
            stg     <= '0;
            ovf_err <= 1'b0;
            out_samp.samp_data <= '0;
            out_samp.samp_ch   <= '0;
            out_samp.samp_str  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                for (int s = 0; s < CIC_N; s++)
                    for (int j = 0; j < CIC_M; j++)
                        dly[c][s][j] <= '0;
        end else begin
            out_samp.samp_str <= 1'b0;
            // A capture arriving while busy is lost
            if (cap_vld && st != IDLE) ovf_err <= 1'b1;
            unique case (st)
                IDLE: begin
                    if (cap_vld) begin
                        x   <= cap_data;
                        ch  <= cap_ch;
                        stg <= '0;
                        st  <= COMB;
                    end
                end
                COMB: begin
                    x <= y;
                    dly[ch][stg][0] <= x;
                    for (int j = 1; j < CIC_M; j++)
                        dly[ch][stg][j] <= dly[ch][stg][j-1];
                    if (stg == LAST_STG) st <= OUT;
                    else stg <= stg + 1'b1;
                end
                OUT: begin
                    out_samp.samp_data <= out_d;
                    out_samp.samp_ch   <= ch;
                    out_samp.samp_str  <= 1'b1;
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cic_d_tdm.sv
// Multichannel TDM CIC decimator: shared integrators, channel
// sequencing, frame counter and decimation capture.
module cic_d_tdm
    import cic_d_tdm_pkg::*;
#(
    parameter int INP_DW    = 18,
    parameter int OUT_DW    = 18,
    parameter int CIC_R_MAX = 16,
    parameter int CIC_N     = 5,
    parameter int CIC_M     = 1,
    parameter int NUM_CH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cfg_r,
    input  logic [7:0]  cfg_shift,
    input  logic        sync_clr,
    cic_d_tdm_if.slave  inp_samp,
    cic_d_tdm_if.master out_samp,
    output logic        seq_err,
    output logic        ovf_err
);
    localparam int CH_W  = (NUM_CH > 1) ? clog2_l(longint'(NUM_CH)) : 1;
    localparam int B_MAX = cic_bmax(CIC_R_MAX, CIC_M, CIC_N, INP_DW);
    localparam logic [15:0] R_MAX = 16'(CIC_R_MAX);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic signed [B_MAX-1:0] acc [NUM_CH][CIC_N];
    logic signed [B_MAX-1:0] acc_nxt [CIC_N];
    logic signed [B_MAX-1:0] x_ext;
    logic [15:0] r_act, r_cfg, r_eff, frm_cnt;
    logic [CH_W-1:0] ch, ch_nxt, exp_ch;
    logic r_ld, ch_ok, str_ok, dec_frm, cap_vld;

    assign ch = inp_samp.samp_ch;

    generate
        if ((2 ** CH_W) == NUM_CH) begin : g_full
            assign ch_ok = 1'b1;
        end else begin : g_part
            assign ch_ok = (ch <= LAST_CH);
        end
    endgenerate

    assign ch_nxt = (ch == LAST_CH) ? '0 : ch + 1'b1;
    assign r_cfg  = (cfg_r == '0)   ? 16'd1 :
                    (cfg_r > R_MAX) ? R_MAX : cfg_r;
    // Until the first sample after clear, the ratio tracks cfg_r
    assign r_eff   = r_ld ? r_cfg : r_act;
    assign dec_frm = (frm_cnt == r_eff - 16'd1);
    assign str_ok  = inp_samp.samp_str & ch_ok & ~sync_clr;
    assign cap_vld = str_ok & dec_frm;
    assign x_ext   = {{(B_MAX-INP_DW){inp_samp.samp_data[INP_DW-1]}},
                      inp_samp.samp_data};

    always_comb begin
        acc_nxt[0] = acc[ch][0] + x_ext;
        for (int k = 1; k < CIC_N; k++)
            acc_nxt[k] = acc[ch][k] + acc[ch][k-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < CIC_N; k++)
                    acc[c][k] <= '0;
            exp_ch  <= '0;
            frm_cnt <= '0;
            r_act   <= 16'd1;
            r_ld    <= 1'b1;
            seq_err <= 1'b0;
        end else if (sync_clr) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < CIC_N; k++)
                    acc[c][k] <= '0;
            exp_ch  <= '0;
            frm_cnt <= '0;
            r_act   <= 16'd1;
            r_ld    <= 1'b1;
            seq_err <= 1'b0;
        end else if (str_ok) begin
            for (int k = 0; k < CIC_N; k++)
                acc[ch][k] <= acc_nxt[k];
            exp_ch <= ch_nxt;
            r_ld   <= 1'b0;
            r_act  <= r_eff;
            if (ch != exp_ch) seq_err <= 1'b1;
            if (ch == LAST_CH) begin
                if (dec_frm) begin
                    frm_cnt <= '0;
                    r_act   <= r_cfg;
                end else begin
                    frm_cnt <= frm_cnt + 16'd1;
                end
            end
        end else if (inp_samp.samp_str) begin
            seq_err <= 1'b1;
        end
    end

    cic_comb_engine #(
        .B_MAX (B_MAX),
        .OUT_DW(OUT_DW),
        .CIC_N (CIC_N),
        .CIC_M (CIC_M),
        .NUM_CH(NUM_CH),
        .CH_W  (CH_W)
    ) u_comb (
        .clk      (clk),
        .reset_n  (reset_n),
        .sync_clr (sync_clr),
        .cfg_shift(cfg_shift),
        .cap_vld  (cap_vld),
        .cap_data (acc_nxt[CIC_N-1]),
        .cap_ch   (ch),
        .out_samp (out_samp),
        .ovf_err  (ovf_err)
    );

endmodule

// File: tb/tb_cic_d_tdm.sv
// Directed bench for cic_d_tdm: 2 channels, N=3, M=1, R_MAX=4, 16-bit.
module tb_cic_d_tdm;
    localparam int INP_DW = 16;
    localparam int OUT_DW = 16;
    localparam int CH_W   = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cfg_r;
    logic [7:0]  cfg_shift;
    logic        sync_clr;
    logic        seq_err, ovf_err;

    cic_d_tdm_if #(.DW(INP_DW), .CH_W(CH_W)) inp_if ();
    cic_d_tdm_if #(.DW(OUT_DW), .CH_W(CH_W)) out_if ();

    cic_d_tdm #(
        .INP_DW   (INP_DW),
        .OUT_DW   (OUT_DW),
        .CIC_R_MAX(4),
        .CIC_N    (3),
        .CIC_M    (1),
        .NUM_CH   (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cfg_r    (cfg_r),
        .cfg_shift(cfg_shift),
        .sync_clr (sync_clr),
        .inp_samp (inp_if.slave),
        .out_samp (out_if.master),
        .seq_err  (seq_err),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int q_data[$];
    int q_ch[$];
    int q_cyc[$];
    int dbl_str = 0;
    logic prev_str = 1'b0;

    always @(negedge clk) begin
        if (out_if.samp_str) begin
            q_data.push_back(int'(out_if.samp_data));
            q_ch.push_back(int'(out_if.samp_ch));
            q_cyc.push_back(cyc);
        end
        if (out_if.samp_str && prev_str) dbl_str++;
        prev_str = out_if.samp_str;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qd(input int i);
        return (i < q_data.size()) ? q_data[i] : -999999;
    endfunction

    function automatic int qc(input int i);
        return (i < q_ch.size()) ? q_ch[i] : -1;
    endfunction

    function automatic int qy(input int i);
        return (i < q_cyc.size()) ? q_cyc[i] : -999999;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int d, input int gap);
        inp_if.samp_ch   = CH_W'(ch);
        inp_if.samp_data = 16'(d);
        inp_if.samp_str  = 1'b1;
        tick(1);
        inp_if.samp_str  = 1'b0;
        tick(gap - 1);
    endtask

    task automatic clr();
        sync_clr = 1'b1;
        tick(1);
        sync_clr = 1'b0;
    endtask

    task automatic q_clear();
        q_data.delete();
        q_ch.delete();
        q_cyc.delete();
    endtask

    task automatic wait_q(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (q_data.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, q_data.size(), n);
    endtask

    int dc0 [4] = '{62, 687, 1000, 1000};
    int dc1 [4] = '{-32, -344, -500, -500};
    int imp [4] = '{3, 12, 1, 0};
    int g_in [8] = '{123, -77, 32767, -32768, 5, 7, 6, 8};
    int g_ex [8] = '{0, 0, 0, 0, 123, -77, 32767, -32768};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s_cyc;
        cfg_r = 16'd4;
        cfg_shift = 8'd0;
        sync_clr = 1'b0;
        inp_if.samp_data = '0;
        inp_if.samp_ch   = '0;
        inp_if.samp_str  = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check("rst_data", int'(out_if.samp_data), 0);
        check("rst_ch", int'(out_if.samp_ch), 0);
        check("rst_flags", int'({out_if.samp_str, seq_err, ovf_err}), 0);

        // DC, ratio 100 clamps to 4
        cfg_r = 16'd100;
        clr();
        q_clear();
        s_cyc = 0;
        for (int f = 0; f < 16; f++) begin
            if (f == 3) s_cyc = cyc;
            send(0, 1000, 8);
            send(1, -500, 8);
        end
        wait_q(8, 20, "dc_cnt");
        for (int i = 0; i < 4; i++) begin
            check("dc_ch0", qd(2*i), dc0[i]);
            check("dc_ch1", qd(2*i+1), dc1[i]);
            check("dc_id0", qc(2*i), 0);
            check("dc_id1", qc(2*i+1), 1);
        end
        check("latency", qy(0) - s_cyc, 5);
        check("dc_rate", qy(2) - qy(0), 64);
        check("dc_flags", int'({seq_err, ovf_err}), 0);

        // sync_clr while the comb engine is busy
        for (int f = 0; f < 3; f++) begin
            send(0, 1000, 8);
            send(1, -500, 8);
        end
        send(0, 1000, 2);
        clr();
        tick(10);
        check("clr_cnt", q_data.size(), 8);
        check("clr_data", int'(out_if.samp_data), 0);
        check("clr_ch", int'(out_if.samp_ch), 0);

        // ratio 4 -> 2 mid-frame, takes effect at the wrap
        cfg_r = 16'd4;
        cfg_shift = 8'd0;
        clr();
        q_clear();
        send(0, 1000, 8);
        send(1, -500, 8);
        send(0, 1000, 8);
        cfg_r = 16'd2;
        send(1, -500, 8);
        for (int f = 0; f < 2; f++) begin
            send(0, 1000, 8);
            send(1, -500, 8);
        end
        check("rc_pre_cnt", q_data.size(), 2);
        check("rc_pre0", qd(0), 62);
        check("rc_pre1", qd(1), -32);
        cfg_shift = 8'd3;
        for (int f = 0; f < 6; f++) begin
            send(0, 1000, 8);
            send(1, -500, 8);
        end
        wait_q(8, 20, "rc_cnt");
        for (int i = 1; i < 4; i++) begin
            check("rc_ch0", qd(2*i), 1000);
            check("rc_ch1", qd(2*i+1), -500);
        end
        check("rc_rate", qy(4) - qy(2), 32);

        // async reset while the comb engine is busy
        send(0, 1000, 8);
        send(1, -500, 8);
        send(0, 1000, 3);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        check("ra_cnt", q_data.size(), 8);
        check("ra_data", int'(out_if.samp_data), 0);
        check("ra_ch", int'(out_if.samp_ch), 0);

        // unit impulse on ch0, R=4, unity gain shift
        cfg_r = 16'd4;
        cfg_shift = 8'd6;
        q_clear();
        for (int f = 0; f < 16; f++) begin
            send(0, (f == 0) ? 1 : 0, 8);
            send(1, 0, 8);
        end
        wait_q(8, 20, "imp_cnt");
        for (int i = 0; i < 4; i++)
            check("imp_ch0", qd(2*i), imp[i]);
        check("imp_ch1", qd(3), 0);

        // ratio 0 acts as 1: two-sample delayed passthrough
        cfg_r = 16'd0;
        clr();
        q_clear();
        for (int i = 0; i < 8; i++)
            send(i % 2, g_in[i], 8);
        wait_q(8, 20, "r1_cnt");
        for (int i = 0; i < 8; i++)
            check("r1_data", qd(i), g_ex[i]);

        // channel sequence error and resync
        clr();
        q_clear();
        send(0, 10, 8);
        check("seq_ok", int'(seq_err), 0);
        send(0, 20, 8);
        check("seq_err", int'(seq_err), 1);
        send(1, 30, 8);
        send(0, 40, 8);
        send(1, 50, 8);
        wait_q(5, 20, "seq_cnt");
        check("seq_dup_ch", qc(1), 0);
        check("seq_resync_ch", qc(3), 0);
        check("seq_resync", qd(3), 10);

        // sync_clr with a strobe: clear wins
        clr();
        q_clear();
        inp_if.samp_ch   = 1'b0;
        inp_if.samp_data = 16'd777;
        inp_if.samp_str  = 1'b1;
        sync_clr = 1'b1;
        tick(1);
        inp_if.samp_str = 1'b0;
        sync_clr = 1'b0;
        tick(7);
        send(0, 1, 8);
        check("cw_cnt", q_data.size(), 1);
        check("cw_seq", int'(seq_err), 0);

        // overflow: captures 2 clocks apart
        clr();
        q_clear();
        send(0, 5, 2);
        send(1, 6, 8);
        tick(8);
        check("ovf_cnt", q_data.size(), 1);
        check("ovf_ch", qc(0), 0);
        check("ovf_err", int'(ovf_err), 1);
        check("ovf_seq", int'(seq_err), 0);
        clr();
        check("ovf_clr", int'(ovf_err), 0);

        check("str_pulse", dbl_str, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
